inst_fetch: RTL

Instruction-fetch stage between the PC register and the IF/ID boundary. Each cycle it presents the current PC to the instruction memory over a request/acknowledge bus and waits for the returned word. It then hands the PC/instruction pair to decode and holds the word if decode is stalled. It also asks the stall controller to freeze the PC until the current fetch completes, and it discards fetched or in-flight instructions on a branch flush.

---
 rtl/inst_fetch_if.sv | 27 ++
 rtl/inst_fetch.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/inst_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and
// instruction memory. At most one request is outstanding at a time.
//   INST_REQ      fetch -> mem  request valid
//   INST_ADDR     fetch -> mem  request address
//   INST_ADDR_OK  mem -> fetch  request accepted this cycle
//   INST_DATA_OK  mem -> fetch  read data valid this cycle
//   INST_RDATA    mem -> fetch  read data
interface inst_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              INST_REQ;
  logic [ADDR_W-1:0] INST_ADDR;
  logic              INST_ADDR_OK;
  logic              INST_DATA_OK;
  logic [DATA_W-1:0] INST_RDATA;

  modport master (
    output INST_REQ, INST_ADDR,
    input  INST_ADDR_OK, INST_DATA_OK, INST_RDATA
  );

  modport slave (
    input  INST_REQ, INST_ADDR,
    output INST_ADDR_OK, INST_DATA_OK, INST_RDATA
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage between the PC register and the IF/ID boundary.
// Presents PC to instruction memory, waits for the word, hands the PC/word
// pair to decode (buffering it while decode is stalled), asks stall control
// to freeze the PC until the fetch completes, and discards fetched or
// in-flight words on a branch flush.
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   PC, CE        fetch address and fetch enable from the PC register
//   FLUSH         branch redirect; kills the current fetch and the decode slot
//   ID_STALL      decode cannot accept a new instruction this cycle
//   IF_STALL_REQ  1 = hold PC
//   bus           instruction-memory request/ack bus (master side)
//   ID_PC, ID_INST, ID_VALID  decode slot
module inst_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] PC,
  input  logic              CE,
  input  logic              FLUSH,
  input  logic              ID_STALL,
  output logic              IF_STALL_REQ,
  inst_fetch_if.master      bus,
  output logic [ADDR_W-1:0] ID_PC,
  output logic [DATA_W-1:0] ID_INST,
  output logic              ID_VALID
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]        state_q,     state_d;
  logic              kill_q,      kill_d;
  logic [ADDR_W-1:0] req_pc_q,    req_pc_d;
  logic [ADDR_W-1:0] hold_pc_q,   hold_pc_d;
  logic [DATA_W-1:0] hold_inst_q, hold_inst_d;
  logic [ADDR_W-1:0] id_pc_q,     id_pc_d;
  logic [DATA_W-1:0] id_inst_q,   id_inst_d;
  logic              id_valid_q,  id_valid_d;

  logic completion;

  // A fetch completes when a live word can go straight into decode, either
  // from the bus or from the hold buffer.
  always_comb begin
    completion = ((state_q == S_WAIT) & bus.INST_DATA_OK & ~kill_q & ~ID_STALL)
               | ((state_q == S_HOLD) & ~ID_STALL);
  end

  assign bus.INST_REQ  = (state_q == S_REQ);
  assign bus.INST_ADDR = PC;
  // During a flush the PC must be free to take the redirect target.
  assign IF_STALL_REQ  = ~FLUSH & ~completion;

  assign ID_PC    = id_pc_q;
  assign ID_INST  = id_inst_q;
  assign ID_VALID = id_valid_q;

  // Fetch FSM
  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    req_pc_d    = req_pc_q;
    hold_pc_d   = hold_pc_q;
    hold_inst_d = hold_inst_q;
    if (!CE) begin
      state_d = S_IDLE;
      kill_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (bus.INST_ADDR_OK) begin
            state_d  = S_WAIT;
            req_pc_d = PC;
            // A flush in the accept cycle already dooms this response.
            kill_d   = FLUSH;
          end
        end
        S_WAIT: begin
          if (bus.INST_DATA_OK) begin
            state_d = S_REQ;
            if (kill_q || FLUSH) begin
              kill_d = 1'b0;
            end else if (ID_STALL) begin
              hold_pc_d   = req_pc_q;
              hold_inst_d = bus.INST_RDATA;
              state_d     = S_HOLD;
            end
          end else if (FLUSH) begin
            // Response still in flight: remember to drop it when it lands.
            kill_d = 1'b1;
          end
        end
        S_HOLD: begin
          if (FLUSH || !ID_STALL) state_d = S_REQ;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Decode slot, in priority order: flush, fetch disabled, stall, load, bubble.
  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    if (FLUSH) begin
      id_pc_d    = '0;
      id_inst_d  = '0;
      id_valid_d = 1'b0;
    end else if (!CE) begin
      id_valid_d = 1'b0;
    end else if (ID_STALL) begin
      id_valid_d = id_valid_q;
    end else if (completion) begin
      id_valid_d = 1'b1;
      if (state_q == S_HOLD) begin
        id_pc_d   = hold_pc_q;
        id_inst_d = hold_inst_q;
      end else begin
        id_pc_d   = req_pc_q;
        id_inst_d = bus.INST_RDATA;
      end
    end else begin
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      kill_q      <= 1'b0;
      req_pc_q    <= '0;
      hold_pc_q   <= '0;
      hold_inst_q <= '0;
      id_pc_q     <= '0;
      id_inst_q   <= '0;
      id_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      req_pc_q    <= req_pc_d;
      hold_pc_q   <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
      id_pc_q     <= id_pc_d;
      id_inst_q   <= id_inst_d;
      id_valid_q  <= id_valid_d;
    end
  end

endmodule
